serial_host_bridge: RTL

Host-side initiator for the serial_fpga command protocol. It accepts parallel register read/write requests and serializes each one as 8N1 UART command bytes on `io_txd`. For reads, it collects the single response byte from `io_rxd`. It sits opposite serial_fpga: it drives the HBA bus over the serial link from a second FPGA, or it replaces the PC in simulation benches.

---
 rtl/serial_proto_pkg.sv | 38 +++
 rtl/uart_rx_sampler.sv | 95 +++++++++
 rtl/serial_host_bridge.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serial_proto_pkg.sv
// Shared framing definitions for the serial_fpga command protocol (host and target side).
// Latency: none, declarations and pure functions only.
// Backpressure: none.
package serial_proto_pkg;

  // Command byte layout: {rnw, 3'b000, periph[3:0]}
  localparam int RNW_BIT        = 7;
  localparam int CMD_PERIPH_LSB = 0;
  localparam int CMD_PERIPH_MSB = 3;

  // Bit slot index of the stop bit within a 10-bit 8N1 frame (0 = start bit)
  localparam logic [3:0] STOP_POS = 4'd9;

  // Host bridge transaction states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_REG   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RWAIT = 3'd4,
    ST_DONE  = 3'd5
  } hb_state_e;

  // Clock cycles per serial bit
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Assemble the command byte from the direction flag and peripheral slot
  function automatic logic [7:0] cmd_byte(input logic rnw, input logic [3:0] periph);
    logic [7:0] b;
    b = '0;
    b[RNW_BIT] = rnw;
    b[CMD_PERIPH_MSB:CMD_PERIPH_LSB] = periph;
    return b;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: synchronizes rxd, validates start/stop bits, pulses o_byte_vld per good byte.
// Latency: o_byte_vld is combinational in the stop-bit sample cycle, about 2 + DIV/2 + 9*DIV cycles after the start edge.
// Backpressure: none; the consumer must take the byte in its vld cycle or lose it.
module uart_rx_sampler #(
  parameter int DIV = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic       o_byte_vld,
  output logic [7:0] o_byte_dat
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    r_sync;
  logic          r_prev;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic w_rxd;
  logic w_tick;

  assign w_rxd      = r_sync[1];
  assign w_tick     = (r_cnt == LAST);
  assign o_byte_vld = (r_state == RX_STOP) && w_tick && w_rxd;
  assign o_byte_dat = r_shift;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
      r_prev <= w_rxd;
    end
  end

  // Frame sequencer: mid-start recheck, then one sample per bit period
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !w_rxd) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            // A line already back high at mid-start was only a glitch
            r_state <= w_rxd ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // Stop-bit sample: a low line is a framing error and simply drops the byte
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_host_bridge.sv
// Host initiator: serializes register read/write requests as 8N1 command bytes, collects the read reply.
// Latency: write completes 30*DIV+1 cycles after accept; read completes one cycle after the reply stop sample or on timeout.
// Backpressure: req_ready is high only in IDLE; one transaction in flight, responses cannot be stalled.
module serial_host_bridge
  import serial_proto_pkg::*;
#(
  parameter int CLK_FREQUENCY     = 50_000_000,
  parameter int BAUD              = 115_200,
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES    = 100_000
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DBUS_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DBUS_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  io_txd,
  input  logic                  io_rxd
);

  localparam int            DIV       = calc_div(CLK_FREQUENCY, BAUD);
  localparam int            CW        = $clog2(DIV);
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES);

  hb_state_e                 r_state;
  logic                      r_rnw;
  logic [REG_ADDR_WIDTH-1:0] r_reg_byte;
  logic [DBUS_WIDTH-1:0]     r_wdata;
  logic [7:0]                r_shift;
  logic [3:0]                r_bit;
  logic [CW-1:0]             r_baud;
  logic                      r_txd;
  logic [TW-1:0]             r_to_cnt;
  logic                      r_rsp_valid;
  logic [DBUS_WIDTH-1:0]     r_rsp_rdata;
  logic                      r_rsp_timeout;

  logic       w_rx_vld;
  logic [7:0] w_rx_dat;
  logic       w_baud_wrap;

  assign w_baud_wrap = (r_baud == BAUD_LAST);
  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign io_txd      = r_txd;

  uart_rx_sampler #(
    .DIV (DIV)
  ) u_rx (
    .i_clk      (hba_clk),
    .i_reset    (hba_reset),
    .i_rxd      (io_rxd),
    .o_byte_vld (w_rx_vld),
    .o_byte_dat (w_rx_dat)
  );

  // Request capture, tx shifter and transaction sequencing
  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      r_state       <= ST_IDLE;
      r_rnw         <= 1'b0;
      r_reg_byte    <= '0;
      r_wdata       <= '0;
      r_shift       <= '0;
      r_bit         <= '0;
      r_baud        <= '0;
      r_txd         <= 1'b1;
      r_to_cnt      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_rnw      <= req_rnw;
            r_reg_byte <= req_addr[REG_ADDR_WIDTH-1:0];
            r_wdata    <= req_wdata;
            r_shift    <= cmd_byte(req_rnw, req_addr[REG_ADDR_WIDTH +: PERIPH_ADDR_WIDTH]);
            r_txd      <= 1'b0;
            r_bit      <= '0;
            r_baud     <= '0;
            r_state    <= ST_CMD;
          end
        end
        ST_CMD, ST_REG, ST_WDATA: begin
          if (!w_baud_wrap) begin
            r_baud <= r_baud + 1'b1;
          end else begin
            r_baud <= '0;
            if (r_bit != STOP_POS) begin
              r_bit <= r_bit + 1'b1;
              if (r_bit == STOP_POS - 4'd1) begin
                r_txd <= 1'b1;
              end else begin
                r_txd   <= r_shift[0];
                r_shift <= {1'b0, r_shift[7:1]};
              end
            end else if (r_state == ST_CMD) begin
              // Next byte's start bit follows the stop bit with no idle gap
              r_shift <= r_reg_byte;
              r_txd   <= 1'b0;
              r_bit   <= '0;
              r_state <= ST_REG;
            end else if (r_state == ST_REG && !r_rnw) begin
              r_shift <= r_wdata;
              r_txd   <= 1'b0;
              r_bit   <= '0;
              r_state <= ST_WDATA;
            end else if (r_state == ST_REG) begin
              r_to_cnt <= '0;
              r_state  <= ST_RWAIT;
            end else begin
              r_rsp_valid   <= 1'b1;
              r_rsp_rdata   <= '0;
              r_rsp_timeout <= 1'b0;
              r_state       <= ST_DONE;
            end
          end
        end
        ST_RWAIT: begin
          // A byte arriving on the timeout cycle still counts as a reply
          if (w_rx_vld) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= w_rx_dat;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_DONE;
          end else if (r_to_cnt == TMO_LAST) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
